// File: rtl/irq_request_latch.sv
// irq_request_latch
// -----------------
// Front-end stage that sits directly upstream of the 8-to-3 priority encoder.
// It synchronizes eight raw request lines and latches them into a pending
// register. Pending requests can be masked. The stage then presents the result
// to the encoder and handshakes the chosen index back in. Only one request is
// in service at a time, and an end-of-interrupt handshake releases it. The
// priority decision itself is left to the encoder.
//
// Ports:
//   clk_i         single clock, all logic on the rising edge
//   reset_i       synchronous active-high reset, clears all state
//   request_i     raw asynchronous request lines, bit 7 highest priority
//   maskWrite_i   load the mask register from maskData_i this cycle
//   maskData_i    new mask value (1 = masked)
//   ack_i         consumer accepts the currently presented request
//   ackIndex_i    index being accepted (encoder output)
//   eoi_i         end of service for the in-service request
//   pending_o     pend & ~mask, feeds the encoder input
//   notEn_o       encoder enable, active-low, 0 only while requesting
//   irq_o         request to the consumer, 1 only while requesting
//   inService_o   one-hot in-service request, all-zero when none
//   mask_o        current mask register
//   ackErr_o      one-cycle pulse on an illegal ack
module irq_request_latch #(
  parameter bit         EDGE_MODE   = 1'b1,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MASK_RESET  = 8'hFF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] request_i,
  input  logic       maskWrite_i,
  input  logic [7:0] maskData_i,
  input  logic       ack_i,
  input  logic [2:0] ackIndex_i,
  input  logic       eoi_i,
  output logic [7:0] pending_o,
  output logic       notEn_o,
  output logic       irq_o,
  output logic [7:0] inService_o,
  output logic [7:0] mask_o,
  output logic       ackErr_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  // Synchronizer chain per line, plus one extra history flop for edge detect.
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] prev_q;
  logic [7:0] syncOut;
  logic [7:0] setVec;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] inService_q, inService_d;
  logic       ackErr_q, ackErr_d;

  logic [7:0] valid;
  logic [7:0] clrVec;
  logic       ackLegal;

  assign syncOut = sync_q[SYNC_STAGES-1];

  // In edge mode a line only pends on its synchronized rising edge.
  // In level mode it pends on every cycle that it is high.
  assign setVec = EDGE_MODE ? (syncOut & ~prev_q) : syncOut;

  // Requests that are pending and not masked.
  assign valid    = pend_q & ~mask_q;
  assign ackLegal = (state_q == REQ) && ack_i && valid[ackIndex_i];

  // Synchronizer and edge-history flops. They clear on reset, so a line that
  // is already high when reset deasserts is seen as one fresh rising edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= request_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= syncOut;
    end
  end

  // Next-state logic for the request FSM, the pend/in-service registers and
  // the mask. The decision is taken against the mask as it stands now, so a
  // mask write only affects the FSM from the following cycle.
  always_comb begin
    state_d     = state_q;
    inService_d = inService_q;
    ackErr_d    = 1'b0;
    clrVec      = '0;
    mask_d      = maskWrite_i ? maskData_i : mask_q;

    unique case (state_q)
      IDLE: begin
        if (ack_i) ackErr_d = 1'b1;
        if (valid != '0) state_d = REQ;
      end
      REQ: begin
        if (ackLegal) begin
          clrVec      = 8'b1 << ackIndex_i;
          inService_d = 8'b1 << ackIndex_i;
          state_d     = SERVICE;
        end else begin
          if (ack_i) ackErr_d = 1'b1;
          if (valid == '0) state_d = IDLE;
        end
      end
      SERVICE: begin
        if (ack_i) ackErr_d = 1'b1;
        if (eoi_i) begin
          inService_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // If a bit is set and cleared in the same cycle, the set wins, so a
    // rising edge that arrives together with its ack is not lost.
    pend_d = (pend_q & ~clrVec) | setVec;
  end

  // State registers. Reset overrides every other input, including a request
  // that is in the middle of service.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      mask_q      <= MASK_RESET;
      inService_q <= '0;
      ackErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      inService_q <= inService_d;
      ackErr_q    <= ackErr_d;
    end
  end

  // Pending is never gated by state. The encoder is enabled only while in REQ.
  assign pending_o   = pend_q & ~mask_q;
  assign irq_o       = (state_q == REQ);
  assign notEn_o     = ~(state_q == REQ);
  assign inService_o = inService_q;
  assign mask_o      = mask_q;
  assign ackErr_o    = ackErr_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Testbench for irq_request_latch. A directed sequence of scenarios is
// followed by randomized traffic. The DUT is checked every cycle against a
// behavioural model, and literal expectations are placed at key points.
module tb_irq_request_latch;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] request;
  logic       maskWrite;
  logic [7:0] maskData;
  logic       ack;
  logic [2:0] ackIndex;
  logic       eoi;
  logic [7:0] pending;
  logic       notEn;
  logic       irq;
  logic [7:0] inService;
  logic [7:0] mask;
  logic       ackErr;

  int total = 0;
  int bad   = 0;

  // Model state: the mode is 0 for idle, 1 for presenting a request and
  // 2 for in service.
  logic [7:0] mPend, mMask, mInSvc;
  logic       mAckErr;
  int         mMode;
  logic [7:0] reqHist[$];

  always #5 clk = ~clk;

  irq_request_latch dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .request_i   (request),
    .maskWrite_i (maskWrite),
    .maskData_i  (maskData),
    .ack_i       (ack),
    .ackIndex_i  (ackIndex),
    .eoi_i       (eoi),
    .pending_o   (pending),
    .notEn_o     (notEn),
    .irq_o       (irq),
    .inService_o (inService),
    .mask_o      (mask),
    .ackErr_o    (ackErr)
  );

  // Keep the last SYNC+1 requests applied at clock edges. The synchronized
  // value is the request from SYNC edges ago. The value from one edge
  // before that is the edge-detect history.
  task automatic modelReset();
    mPend   = 8'h00;
    mMask   = 8'hFF;
    mInSvc  = 8'h00;
    mAckErr = 1'b0;
    mMode   = 0;
    reqHist.delete();
    for (int i = 0; i <= SYNC; i++) reqHist.push_back(8'h00);
  endtask

  task automatic modelEdge();
    logic [7:0] s, prev, rise, avail, clr;
    if (reset) begin
      modelReset();
    end else begin
      s     = reqHist[1];
      prev  = reqHist[0];
      rise  = s & ~prev;
      avail = mPend & ~mMask;
      clr   = 8'h00;
      mAckErr = 1'b0;
      if (mMode == 1) begin
        if (ack && avail[ackIndex]) begin
          clr    = 8'h01 << ackIndex;
          mInSvc = 8'h01 << ackIndex;
          mMode  = 2;
        end else begin
          mAckErr = ack;
          if (avail == 8'h00) mMode = 0;
        end
      end else if (mMode == 2) begin
        mAckErr = ack;
        if (eoi) begin
          mInSvc = 8'h00;
          mMode  = 0;
        end
      end else begin
        mAckErr = ack;
        if (avail != 8'h00) mMode = 1;
      end
      mPend = (mPend & ~clr) | rise;
      if (maskWrite) mMask = maskData;
      reqHist.push_back(request);
      void'(reqHist.pop_front());
    end
  endtask

  task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("pending",   pending,        mPend & ~mMask);
    checkOne("irq",       {7'd0, irq},    {7'd0, mMode == 1});
    checkOne("notEn",     {7'd0, notEn},  {7'd0, mMode != 1});
    checkOne("inService", inService,      mInSvc);
    checkOne("mask",      mask,           mMask);
    checkOne("ackErr",    {7'd0, ackErr}, {7'd0, mAckErr});
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic mw,
                               input logic [7:0] md, input logic a,
                               input logic [2:0] ai, input logic e);
    reset = r; request = rq; maskWrite = mw; maskData = md;
    ack = a; ackIndex = ai; eoi = e;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idleCycle(input logic [7:0] rq);
    applyStimulus(1'b0, rq, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  function automatic logic [2:0] topBit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  initial begin
    modelReset();
    reset = 1'b1; request = 8'h00; maskWrite = 1'b0; maskData = 8'h00;
    ack = 1'b0; ackIndex = 3'd0; eoi = 1'b0;

    // Reset state.
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOne("lit_reset_mask", mask, 8'hFF);
    checkOne("lit_reset_notEn", {7'd0, notEn}, 8'h01);
    checkOne("lit_reset_pending", pending, 8'h00);

    // Unmask, then pulse bit 2 and check the pend and irq latency.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    idleCycle(8'h04);
    idleCycle(8'h00);
    checkOne("lit_lat_pend_early", pending, 8'h00);
    idleCycle(8'h00);
    checkOne("lit_lat_pend", pending, 8'h04);
    checkOne("lit_lat_irq_early", {7'd0, irq}, 8'h00);
    idleCycle(8'h00);
    checkOne("lit_lat_irq", {7'd0, irq}, 8'h01);
    checkOne("lit_lat_notEn", {7'd0, notEn}, 8'h00);

    // Bring bit 7 in as well, ack it, then end its service.
    idleCycle(8'h80);
    idleCycle(8'h00);
    idleCycle(8'h00);
    checkOne("lit_p84", pending, 8'h84);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0);
    checkOne("lit_ack7_insvc", inService, 8'h80);
    checkOne("lit_ack7_pending", pending, 8'h04);
    checkOne("lit_ack7_irq", {7'd0, irq}, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    checkOne("lit_eoi_insvc", inService, 8'h00);
    idleCycle(8'h00);
    checkOne("lit_reenter_irq", {7'd0, irq}, 8'h01);
    checkOne("lit_reenter_pending", pending, 8'h04);

    // An illegal ack raises a single-cycle error pulse.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0);
    checkOne("lit_ackerr", {7'd0, ackErr}, 8'h01);
    checkOne("lit_ackerr_irq", {7'd0, irq}, 8'h01);
    checkOne("lit_ackerr_pending", pending, 8'h04);
    idleCycle(8'h00);
    checkOne("lit_ackerr_drop", {7'd0, ackErr}, 8'h00);

    // Serve bit 2, gather bit 0, then mask it and unmask it again.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
    idleCycle(8'h01);
    idleCycle(8'h00);
    idleCycle(8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    idleCycle(8'h00);
    checkOne("lit_p01_irq", {7'd0, irq}, 8'h01);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
    checkOne("lit_mask_pending", pending, 8'h00);
    idleCycle(8'h00);
    checkOne("lit_mask_irq", {7'd0, irq}, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOne("lit_unmask_pending", pending, 8'h01);
    checkOne("lit_unmask_irq_early", {7'd0, irq}, 8'h00);
    idleCycle(8'h00);
    checkOne("lit_unmask_irq", {7'd0, irq}, 8'h01);

    // A new rising edge on bit 1 lands on the same cycle as its ack.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    idleCycle(8'h02);
    idleCycle(8'h00);
    idleCycle(8'h00);
    idleCycle(8'h00);
    idleCycle(8'h02);
    idleCycle(8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0);
    checkOne("lit_setwins_insvc", inService, 8'h02);
    checkOne("lit_setwins_pending", pending, 8'h02);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    idleCycle(8'h00);
    checkOne("lit_setwins_reenter", {7'd0, irq}, 8'h01);

    // Reset asserted while a request is in service.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0);
    idleCycle(8'hF0);
    idleCycle(8'h00);
    idleCycle(8'h00);
    checkOne("lit_pF0", pending, 8'hF0);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    checkOne("lit_rst_insvc", inService, 8'h00);
    checkOne("lit_rst_mask", mask, 8'hFF);
    checkOne("lit_rst_notEn", {7'd0, notEn}, 8'h01);
    checkOne("lit_rst_pending", pending, 8'h00);

    // Randomized traffic.
    begin
      logic [7:0] rq;
      rq = 8'h00;
      for (int n = 0; n < 3000; n++) begin
        logic       r, mw, a, e;
        logic [7:0] md;
        logic [2:0] ai;
        r  = ($urandom_range(0, 299) == 0);
        rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        mw = ($urandom_range(0, 15) == 0);
        md = 8'($urandom) & 8'($urandom);
        a  = ($urandom_range(0, 3) == 0);
        ai = $urandom_range(0, 1) ? topBit(mPend & ~mMask) : 3'($urandom_range(0, 7));
        e  = ($urandom_range(0, 5) == 0);
        applyStimulus(r, rq, mw, md, a, ai, e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Front-end stage directly upstream of the 8-to-3 priority encoder; turns eight raw asynchronous request lines into a registered, maskable pending vector.
- Drives the encoder's Input and notEN, and accepts back the encoded index through an Ack/AckIndex handshake.
- Tracks one in-service request at a time with an end-of-interrupt handshake.
- No nesting; the priority decision itself stays in the encoder.

Parameters:
- EDGE_MODE, 1, 1 = pending set on synchronized rising edge; 0 = level mode, pending set every cycle the synchronized line is high
- SYNC_STAGES, 2, flip-flop depth of the per-line input synchronizer (legal 2..4)
- MASK_RESET, 8'hFF, Mask register value after reset (1 = masked)

Ports:
- Clock  in  1  single clock, all logic rising-edge
- Reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
- Request  in  8  raw asynchronous request lines, bit 7 highest priority
- MaskWrite  in  1  load Mask from MaskData this cycle
- MaskData  in  8  new mask value
- Ack  in  1  consumer accepts the currently presented request
- AckIndex  in  3  index being accepted (encoder Output)
- EOI  in  1  end of service for the in-service request
- Pending  out  8  Pend & ~Mask; feeds encoder Input
- notEN  out  1  encoder enable, active-low; 0 only in state REQ
- Irq  out  1  request to consumer; 1 only in state REQ
- InService  out  8  one-hot in-service request, all-zero when none
- Mask  out  8  current mask register
- AckErr  out  1  one-cycle pulse on an illegal Ack

Behaviour:
- Reset values:
  - Pend = 0, InService = 0, Mask = MASK_RESET, AckErr = 0
  - State = IDLE, so Irq = 0 and notEN = 1
  - Synchronizers and edge-history flops are 0; a line already high when Reset deasserts produces one rising edge.
- Synchronizer and edge detect:
  - Each Request bit passes through SYNC_STAGES flops, giving s[i].
  - Edge detect is s[i] & ~prev[i], where prev is s delayed one cycle.
  - set[i] = edge (EDGE_MODE=1) or s[i] (EDGE_MODE=0).
- Latency:
  - Request captured at edge k → Pend bit visible after edge k+SYNC_STAGES.
  - Irq=1 / notEN=0 after edge k+SYNC_STAGES+1.
  - With defaults, Irq asserts 3 cycles after capture.
- Pending output: Pending is combinational from registers (Pend & ~Mask); it is never gated by state.
- Mask:
  - On MaskWrite, Mask <= MaskData at the next edge.
  - Masking never clears Pend or InService; unmasking re-exposes held pends.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if (Pend & ~Mask) != 0, go to REQ.
  - REQ, no valid pending remains (e.g. after a MaskWrite masks all): go to IDLE, Irq drops on that edge, no error.
  - REQ, Ack with (Pend & ~Mask)[AckIndex] = 1: clear Pend[AckIndex], set InService to one-hot(AckIndex), go to SERVICE.
  - REQ, Ack with that bit = 0: AckErr = 1 for one cycle, stay in REQ, no state change.
  - SERVICE: Irq = 0, notEN = 1; new requests keep accumulating in Pend. On EOI, clear InService and go to IDLE; REQ follows on the next edge if anything is pending.
  - Ack outside REQ: ignored, AckErr pulse.
  - EOI outside SERVICE: ignored, no error.
- Simultaneous events:
  - Set and clear on the same Pend bit in the same cycle: set wins; bit stays 1 and InService is still loaded.
  - Ack and EOI together in REQ: Ack is taken, EOI ignored.
  - Reset overrides every input in the same cycle, including mid-SERVICE; InService clears and no EOI is required.
- Level mode: a line held high re-pends the cycle after its Ack clears it. The consumer must drop the source before EOI to avoid re-entry.

Test Plan:
- Reset with MASK_RESET=FF, write Mask=00, pulse Request=8'b00000100 for one cycle → Pend bit 2 after 2 cycles, Irq=1 / notEN=0 after 3, Pending=8'h04.
- In REQ with Pending=8'h84, Ack with AckIndex=7 → InService=8'h80, Pending=8'h04, Irq=0, notEN=1. Then EOI → IDLE, then REQ next cycle with Pending=8'h04.
- In REQ, Ack with AckIndex=3 while Pending=8'h04 → AckErr high exactly one cycle, state stays REQ, Pending unchanged.
- Pend=8'h01 in REQ, MaskWrite=1, MaskData=8'h01 → Irq=0 next cycle, Pending=0, Pend bit 0 retained. Unmask → Irq returns one cycle after Pending=8'h01 is exposed.
- Second rising edge on bit 1 in the same cycle Ack clears Pend[1] → InService=8'h02 and Pend[1] still 1. After EOI, REQ re-enters with Pending=8'h02.
- Assert Reset during SERVICE with Pend=8'hF0 → next cycle all outputs at reset values, Irq=0, notEN=1, Mask=8'hFF.
